// File: rtl/mant_div_seq.sv
// mant_div_seq: restoring mantissa divider, one quotient bit per clock (clk, rst_n, start, dividend, divisor -> busy, done, quotient, rem_nonzero, div_err)
module mant_div_seq #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             rem_nonzero,
  output logic             div_err
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0] r, diff;
  logic [CW-1:0] cnt;
  logic ge;
  assign ge = r >= {1'b0, d};
  assign diff = ge ? r - {1'b0, d} : r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? (divisor[WIDTH-1] ? RUN : DONE) : IDLE) :
               state == RUN  ? (cnt == '0 ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      rem_nonzero <= 1'b0;
      div_err     <= 1'b0;
    end else if (state == IDLE && start) begin
      rem_nonzero <= 1'b0;
      if (divisor[WIDTH-1]) begin
        d        <= divisor;
        r        <= {1'b0, dividend};
        cnt      <= CW'(WIDTH - 1);
        quotient <= '0;
        div_err  <= 1'b0;
      end else begin
        quotient <= '1;
        div_err  <= 1'b1;
      end
    end else if (state == RUN) begin
      r        <= {diff[WIDTH-1:0], 1'b0};
      quotient <= {quotient[WIDTH-2:0], ge};
      cnt      <= cnt - 1'b1;
      if (cnt == '0) rem_nonzero <= diff != '0;
    end
endmodule

// File: tb/tb_mant_div_seq.sv
// tb_mant_div_seq: directed and random checks of mant_div_seq against an arithmetic reference
module tb_mant_div_seq;
  localparam int W = 24;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, rem_nonzero, div_err;
  logic [W-1:0] quotient;
  int n_assert = 0, n_fail = 0;
  mant_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .rem_nonzero(rem_nonzero), .div_err(div_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned n;
    if (!b[W-1]) return {1'b1, 1'b0, {W{1'b1}}};
    n = longint'(a) << (W - 1);
    return {1'b0, (n % b) != 0, W'(n / b)};
  endfunction
  task automatic finish_check(input string tag, input logic [W+1:0] e, input int lat0);
    int lat;
    lat = lat0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, e[W+1] ? 1 : W + 1);
    chk({tag, " busy@done"}, busy, 1);
    chk({tag, " quotient"}, quotient, e[W-1:0]);
    chk({tag, " rem_nonzero"}, rem_nonzero, e[W]);
    chk({tag, " div_err"}, div_err, e[W+1]);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " held"}, quotient, e[W-1:0]);
  endtask
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    chk({tag, " busy"}, busy, 1);
    finish_check(tag, model(a, b), 1);
  endtask
  initial begin
    int lat, seen;
    logic [W-1:0] a, b;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset flags", {rem_nonzero, div_err}, 0);
    rst_n = 1'b1;
    run(24'h800000, 24'h800000, "one");
    chk("one const", quotient, 24'h800000);
    run(24'h800000, 24'hC00000, "two_thirds");
    chk("two_thirds const", quotient, 24'h555555);
    chk("two_thirds rnz", rem_nonzero, 1);
    run(24'h123456, 24'h000000, "div0");
    chk("div0 const", quotient, 24'hFFFFFF);
    run(24'h123456, 24'h400000, "unnorm");
    chk("unnorm err", div_err, 1);
    @(negedge clk);
    dividend = 24'hFFFFFF;
    divisor = 24'h800000;
    start = 1'b1;
    @(negedge clk);
    dividend = 24'hC00000;
    finish_check("b2b first", model(24'hFFFFFF, 24'h800000), 1);
    chk("b2b first const", quotient, 24'hFFFFFF);
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted", busy, 1);
    chk("b2b cleared", quotient, 0);
    finish_check("b2b second", model(24'hC00000, 24'h800000), 1);
    chk("b2b second const", quotient, 24'hC00000);
    @(negedge clk);
    dividend = 24'hABCDEF;
    divisor = 24'h9F0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1;
    divisor = 24'h000000;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    finish_check("ignore", model(24'hABCDEF, 24'h9F0001), lat);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    chk("ignore no extra", seen, 0);
    @(negedge clk);
    dividend = 24'h800000;
    divisor = 24'hC00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst quotient", quotient, 0);
    chk("async rst flags", {rem_nonzero, div_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    chk("after rst quiet", seen, 0);
    run(24'h800000, 24'hC00000, "after rst");
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 5 != 0) b[W-1] = 1'b1;
      run(a, b, $sformatf("rand%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mant_div_seq.md
Name: mant_div_seq

Overview:
- Multi-cycle restoring divider for floating-point mantissas. Produces one quotient bit per clock, MSB first.
- Sits in the FP divide datapath upstream of the divider's leading-one detector and normalizer.
- Output quotient has its MSB at bit WIDTH-1 or WIDTH-2. The downstream leading-one detector and normalizer locate that bit and shift it.
- Start/done handshake. Results are held until the next accepted start.

Parameters:
WIDTH, 24, mantissa width including hidden bit (dividend, divisor and quotient width)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  dividend mantissa, any value
divisor  input  WIDTH  divisor mantissa; must have bit WIDTH-1 set for a valid divide
busy  output  1  high whenever state is not IDLE
done  output  1  single-cycle pulse; result outputs valid from this cycle on
quotient  output  WIDTH  floor(dividend * 2^(WIDTH-1) / divisor), truncated
rem_nonzero  output  1  sticky: final remainder is not zero
div_err  output  1  divisor bit WIDTH-1 was 0 (includes divisor==0)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, quotient, rem_nonzero, div_err and all internal registers = 0.
  - Reset mid-operation aborts the divide. No done is produced. Behaviour resumes from IDLE after release.
- States: IDLE, RUN, DONE.
- IDLE, start=1 and divisor[WIDTH-1]=1:
  - Capture divisor into D.
  - Partial remainder R (WIDTH+1 bits) = zero-extended dividend.
  - Bit counter cnt = WIDTH-1.
  - Clear quotient shift register and flags. Go to RUN.
- IDLE, start=1 and divisor[WIDTH-1]=0:
  - quotient = all ones, div_err=1, rem_nonzero=0. Go to DONE.
- RUN, each edge:
  - If R >= D: q bit = 1 and R = (R-D)<<1. Otherwise q bit = 0 and R = R<<1.
  - Shift q bit into the quotient LSB. cnt decrements.
  - On the edge where cnt==0: rem_nonzero = (remainder before the final shift != 0), then go to DONE.
  - Exactly WIDTH RUN edges.
- Width guarantee: the normalized divisor gives dividend < 2^WIDTH <= 2*D. R therefore never needs more than one subtraction per step and WIDTH+1 bits never overflow.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency:
  - Start accepted at edge k. Valid divide: done high in the cycle after edge k+WIDTH. Error path: done high in the cycle after edge k.
  - Back-to-back starts are possible with start held high. A new start is accepted on the first edge with busy=0, which is the edge leaving DONE+1.
- start while busy (RUN or DONE) is ignored. Operands on input ports may change freely after acceptance.
- quotient, rem_nonzero and div_err hold their values from done until the next accepted start. They clear on acceptance.
- quotient is a registered shift register. Intermediate values during RUN are visible but not valid until done.
- Simultaneous reset and start: reset wins.

Test Plan:
- dividend=0x800000, divisor=0x800000, start pulse at edge k -> done in cycle after edge k+24, quotient=0x800000, rem_nonzero=0, div_err=0; busy high from k+1 through the done cycle.
- dividend=0x800000, divisor=0xC00000 -> quotient=0x555555 (MSB at bit 22), rem_nonzero=1.
- dividend=0xFFFFFF, divisor=0x800000 -> quotient=0xFFFFFF, rem_nonzero=0; then dividend=0xC00000, divisor=0x800000 back-to-back with start held high -> second result 0xC00000, accepted on the first busy=0 edge.
- divisor=0x000000 and divisor=0x400000 (separate runs) -> done one edge after start, quotient=0xFFFFFF, div_err=1, no RUN cycles.
- start re-asserted during RUN with divisor=0 -> ignored; first operation's result and single done pulse unaffected.
- rst_n pulsed low 10 cycles into RUN -> all outputs 0 immediately (asynchronously), no done; a fresh start afterwards completes with the correct result.
